// File: rtl/wb_fwd_buffer.sv
// Writeback forwarding buffer: ring of the last DEPTH register writebacks with NUM_RD
// zero-latency lookup ports. Optional same-cycle bypass via `define WB_FWD_BYPASS_EN.
module wb_fwd_buffer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            flush,
  input  logic                            push_en,
  input  logic [4:0]                      push_addr,
  input  logic [XLEN-1:0]                 push_data,
  input  logic [NUM_RD*5-1:0]             q_addr,
  output logic [NUM_RD-1:0]               q_hit,
  output logic [NUM_RD*XLEN-1:0]          q_data,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            full
);

  localparam int unsigned AW    = 5;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic             r_valid [DEPTH];
  logic [AW-1:0]    r_addr  [DEPTH];
  logic [XLEN-1:0]  r_data  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;

  // x0 is hard-wired, so writes to it never occupy an entry
  assign w_push = push_en && (push_addr != AW'(0)) && !stall && !flush;

  // Storage update; reset > flush > stall > push
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_addr[k]  <= '0;
        r_data[k]  <= '0;
      end
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
      end
      r_count <= '0;
    end else if (w_push) begin
      r_valid[r_wr_ptr] <= 1'b1;
      r_addr[r_wr_ptr]  <= push_addr;
      r_data[r_wr_ptr]  <= push_data;
      r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      if (r_count != CNT_W'(DEPTH)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the last one assigned
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    logic [AW-1:0]    w_qa;
    q_hit  = '0;
    q_data = '0;
    w_idx  = '0;
    w_qa   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_qa = q_addr[i*AW +: AW];
      for (int age = DEPTH; age >= 1; age--) begin
        w_idx = r_wr_ptr - PTR_W'(age);
        if (r_valid[w_idx] && (r_addr[w_idx] == w_qa) && (w_qa != AW'(0))) begin
          q_hit[i]                 = 1'b1;
          q_data[i*XLEN +: XLEN]   = r_data[w_idx];
        end
      end
`ifdef WB_FWD_BYPASS_EN
      if (w_push && (push_addr == w_qa)) begin
        q_hit[i]               = 1'b1;
        q_data[i*XLEN +: XLEN] = push_data;
      end
`endif
    end
  end

  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_wb_fwd_buffer.sv
// Directed bench for wb_fwd_buffer (DEPTH=4, NUM_RD=2, XLEN=32); honours WB_FWD_BYPASS_EN.
module tb_wb_fwd_buffer;

  logic        clk = 1'b0;
  logic        reset, stall, flush, push_en;
  logic [4:0]  push_addr;
  logic [31:0] push_data;
  logic [9:0]  q_addr;
  logic [1:0]  q_hit;
  logic [63:0] q_data;
  logic [2:0]  count;
  logic        full;

  int unsigned passes = 0;
  int unsigned total  = 0;

  wb_fwd_buffer #(.XLEN(32), .DEPTH(4), .NUM_RD(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .push_en(push_en), .push_addr(push_addr), .push_data(push_data),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    push_en = 1'b1; push_addr = a; push_data = d;
    tick();
    push_en = 1'b0; push_addr = '0; push_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic query(input logic [4:0] a0, input logic [4:0] a1);
    q_addr = {a1, a0};
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; push_en = 1'b0;
    push_addr = '0; push_data = '0; q_addr = '0;
    tick(); tick();
    reset = 1'b1;
    query(5'd5, 5'd6);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full",  64'(full),  64'd0);
    check("rst_hit",   64'(q_hit), 64'd0);

    // Reset mid-burst, with a push presented during the reset cycle
    push(5'd5, 32'h0000_0A05);
    push(5'd6, 32'h0000_0A06);
    push(5'd8, 32'h0000_0A08);
    check("burst_count", 64'(count), 64'd3);
    reset = 1'b0; push_en = 1'b1; push_addr = 5'd9; push_data = 32'h99;
    tick();
    reset = 1'b1; push_en = 1'b0; push_addr = '0; push_data = '0;
    query(5'd5, 5'd9);
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_full",  64'(full),  64'd0);
    check("rst2_hit",   64'(q_hit), 64'd0);
    check("rst2_data",  q_data,     64'd0);

    // Basic hit and miss on independent ports
    push(5'd5, 32'hDEAD_BEEF);
    query(5'd5, 5'd6);
    check("basic_hit",   64'(q_hit), 64'b01);
    check("basic_data0", 64'(q_data[31:0]), 64'hDEAD_BEEF);
    check("basic_data1", 64'(q_data[63:32]), 64'd0);
    check("basic_count", 64'(count), 64'd1);

    // Newest of duplicate rd wins; both entries still counted
    do_reset();
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    query(5'd7, 5'd7);
    check("newest_hit",   64'(q_hit), 64'b11);
    check("newest_data",  q_data, {32'h22, 32'h22});
    check("newest_count", 64'(count), 64'd2);

    // Wrap: fifth push overwrites the oldest (rd=1)
    do_reset();
    for (int i = 1; i <= 5; i++) push(5'(i), 32'(i * 16));
    query(5'd1, 5'd5);
    check("wrap_count", 64'(count), 64'd4);
    check("wrap_full",  64'(full),  64'd1);
    check("wrap_hit",   64'(q_hit), 64'b10);
    check("wrap_data5", 64'(q_data[63:32]), 64'h50);
    query(5'd2, 5'd4);
    check("wrap_oldest", q_data, {32'h40, 32'h20});

    // x0 push ignored, x0 query never hits
    push(5'd0, 32'h99);
    query(5'd0, 5'd2);
    check("x0_count", 64'(count), 64'd4);
    check("x0_hit",   64'(q_hit), 64'b10);

    // Stall blocks a push
    stall = 1'b1;
    push(5'd12, 32'h77);
    stall = 1'b0;
    query(5'd12, 5'd2);
    check("stall_hit",   64'(q_hit), 64'b10);
    check("stall_count", 64'(count), 64'd4);

    // Flush clears everything and drops the concurrent push
    flush = 1'b1;
    push(5'd9, 32'h88);
    flush = 1'b0;
    query(5'd9, 5'd5);
    check("flush_count", 64'(count), 64'd0);
    check("flush_full",  64'(full),  64'd0);
    check("flush_hit",   64'(q_hit), 64'd0);
    push(5'd10, 32'hAA);
    query(5'd10, 5'd5);
    check("postflush_hit",  64'(q_hit), 64'b01);
    check("postflush_data", 64'(q_data[31:0]), 64'hAA);

    // Same-cycle push and query
    do_reset();
    push_en = 1'b1; push_addr = 5'd3; push_data = 32'hAB;
    query(5'd3, 5'd4);
`ifdef WB_FWD_BYPASS_EN
    check("byp_hit",  64'(q_hit), 64'b01);
    check("byp_data", q_data, 64'hAB);
`else
    check("byp_hit",  64'(q_hit), 64'b00);
    check("byp_data", q_data, 64'h0);
`endif
    tick();
    push_en = 1'b0; push_addr = '0; push_data = '0;
    #1;
    check("byp_next_hit",   64'(q_hit), 64'b01);
    check("byp_next_data",  q_data, 64'hAB);
    check("byp_next_count", 64'(count), 64'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
